// File: rtl/smi_pkg.sv
// rtl/smi_pkg.sv - shared types, constants and default geometry for the SMI line receiver
`ifndef LEDS
`define LEDS 16
`endif
`ifndef FIFO_LINES
`define FIFO_LINES 4
`endif
`ifndef LINES
`define LINES 64
`endif

package smi_pkg;

    localparam int BYTES_PER_LED = 4;

    typedef logic [31:0] led_word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } smi_rx_state_e;

    // Counter width for an index range of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smi_line_rx_if.sv
// rtl/smi_line_rx_if.sv - write port from the receiver into the downstream line buffer
interface smi_line_rx_if
    import smi_pkg::*;
#(
    parameter int LED_W  = 1,
    parameter int LINE_W = 1
);
    logic              wr_en_o;
    led_word_t         wr_data_o;
    logic [LED_W-1:0]  wr_led_o;
    logic [LINE_W-1:0] wr_line_o;
    logic              line_done_o;
    logic [7:0]        free_lines_i;

    modport master (
        output wr_en_o, wr_data_o, wr_led_o, wr_line_o, line_done_o,
        input  free_lines_i
    );

    modport slave (
        input  wr_en_o, wr_data_o, wr_led_o, wr_line_o, line_done_o,
        output free_lines_i
    );
endinterface

// File: rtl/smi_sync.sv
// rtl/smi_sync.sv - parameterised-width two-flop synchroniser with async active-low reset
module smi_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops resolve metastability of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/smi_line_rx.sv
// rtl/smi_line_rx.sv - SMI write-bus byte-to-LED-word receiver (option macro: SMI_LINE_RX_OVERRUN_EN)
module smi_line_rx
    import smi_pkg::*;
#(
    parameter int LEDS       = `LEDS,
    parameter int FIFO_LINES = `FIFO_LINES,
    parameter int LINES      = `LINES
) (
    input  logic          clk_i,
    input  logic          global_rst_n,
    input  logic          smi_nwe_i,
    input  logic [7:0]    smi_data_i,
    input  logic          frame_opto_i,
    output logic          busy_o,
    output logic          frame_rst_o,
    output logic          err_o,
    smi_line_rx_if.master lb
);
    localparam int LED_W  = cnt_width(LEDS);
    localparam int LINE_W = cnt_width(LINES);

    logic nwe_s, opto_s, nwe_d, opto_d, rise_q, frame_q;
    logic [7:0] data_s, data_lat;
    logic [1:0] byte_cnt;
    logic [23:0] word_lo;
    logic [LED_W-1:0] led_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [7:0] burst_cnt;
    logic commit, drop_now, word_done, line_end, burst_end, busy_next;
    smi_rx_state_e state, state_next;

    // nwe idles high, so its synchroniser resets high to avoid a false rising edge.
    smi_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_nwe (
        .clk(clk_i), .rst_n(global_rst_n), .d(smi_nwe_i), .q(nwe_s));
    smi_sync #(.WIDTH(8), .RST_VAL(8'h00)) u_sync_data (
        .clk(clk_i), .rst_n(global_rst_n), .d(smi_data_i), .q(data_s));
    smi_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_opto (
        .clk(clk_i), .rst_n(global_rst_n), .d(frame_opto_i), .q(opto_s));

    // Edge stage: registered strobe/frame edge pulses; the byte is captured on strobe fall.
    always_ff @(posedge clk_i or negedge global_rst_n) begin
        if (!global_rst_n) begin
            nwe_d    <= 1'b1;
            opto_d   <= 1'b0;
            rise_q   <= 1'b0;
            frame_q  <= 1'b0;
            data_lat <= 8'h00;
        end else begin
            nwe_d   <= nwe_s;
            opto_d  <= opto_s;
            rise_q  <= nwe_s & ~nwe_d;
            frame_q <= opto_s & ~opto_d;
            if (nwe_d && !nwe_s) begin
                data_lat <= data_s;
            end
        end
    end

    // A frame edge coinciding with a commit wins: the byte is simply never committed.
    assign commit    = rise_q & ~frame_q;
    assign word_done = commit && !drop_now && (byte_cnt == 2'(BYTES_PER_LED - 1));
    assign line_end  = word_done && (led_cnt == LED_W'(LEDS - 1));
    assign burst_end = line_end && (burst_cnt == 8'(FIFO_LINES - 1));

`ifdef SMI_LINE_RX_OVERRUN_EN
    logic frame_full, err_q;

    assign drop_now = (state == S_DROP) || frame_full;
    assign err_o    = err_q;

    // End-of-frame marker and sticky error: extra bytes or a frame edge that cuts a word.
    always_ff @(posedge clk_i or negedge global_rst_n) begin
        if (!global_rst_n) begin
            frame_full <= 1'b0;
            err_q      <= 1'b0;
        end else if (frame_q) begin
            frame_full <= 1'b0;
            if (byte_cnt != 2'd0) begin
                err_q <= 1'b1;
            end
        end else if (commit) begin
            if (drop_now) begin
                err_q <= 1'b1;
            end else if (line_end && (line_cnt == LINE_W'(LINES - 1))) begin
                frame_full <= 1'b1;
            end
        end
    end
`else
    assign drop_now = 1'b0;
    assign err_o    = 1'b0;
`endif

    // FSM state register plus the registered busy flag it drives.
    always_ff @(posedge clk_i or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state  <= S_IDLE;
            busy_o <= 1'b1;
        end else begin
            state  <= state_next;
            busy_o <= busy_next;
        end
    end

    // FSM next state: a burst opens on its first byte and closes after FIFO_LINES lines.
    always_comb begin
        state_next = state;
        if (frame_q) begin
            state_next = S_IDLE;
        end else if (commit) begin
            case (state)
                S_IDLE:  state_next = drop_now ? S_DROP : S_RECV;
                S_RECV: begin
                    if (drop_now) begin
                        state_next = S_DROP;
                    end else if (burst_end) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // FSM output: host is held off while receiving or when the buffer lacks a burst of room.
    always_comb begin
        busy_next = (state_next == S_RECV) || (lb.free_lines_i < 8'(FIFO_LINES));
    end

    // Byte assembly, LED/line/burst counting and the registered write port.
    always_ff @(posedge clk_i or negedge global_rst_n) begin
        if (!global_rst_n) begin
            byte_cnt       <= 2'd0;
            word_lo        <= 24'h0;
            led_cnt        <= '0;
            line_cnt       <= '0;
            burst_cnt      <= 8'd0;
            frame_rst_o    <= 1'b0;
            lb.wr_en_o     <= 1'b0;
            lb.wr_data_o   <= '0;
            lb.wr_led_o    <= '0;
            lb.wr_line_o   <= '0;
            lb.line_done_o <= 1'b0;
        end else begin
            lb.wr_en_o     <= 1'b0;
            lb.line_done_o <= 1'b0;
            if (frame_q) begin
                frame_rst_o <= 1'b1;
                byte_cnt    <= 2'd0;
                led_cnt     <= '0;
                line_cnt    <= '0;
                burst_cnt   <= 8'd0;
            end else if (commit) begin
                frame_rst_o <= 1'b0;
                if (!drop_now) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    word_lo[7:0]   <= data_lat;
                        2'd1:    word_lo[15:8]  <= data_lat;
                        2'd2:    word_lo[23:16] <= data_lat;
                        default: word_lo        <= word_lo;
                    endcase
                end
                if (word_done) begin
                    lb.wr_en_o   <= 1'b1;
                    lb.wr_data_o <= {data_lat, word_lo};
                    lb.wr_led_o  <= led_cnt;
                    lb.wr_line_o <= line_cnt;
                    if (line_end) begin
                        led_cnt        <= '0;
                        lb.line_done_o <= 1'b1;
                        line_cnt       <= (line_cnt == LINE_W'(LINES - 1)) ? '0 : line_cnt + 1'b1;
                        burst_cnt      <= burst_end ? 8'd0 : burst_cnt + 8'd1;
                    end else begin
                        led_cnt <= led_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_smi_line_rx.sv
// tb/tb_smi_line_rx.sv - randomized self-checking bench for smi_line_rx against a word-stream model
module tb_smi_line_rx;
    import smi_pkg::*;

    localparam int LEDS       = 2;
    localparam int FIFO_LINES = 4;
    localparam int LINES      = 4;
    localparam int LED_W      = cnt_width(LEDS);
    localparam int LINE_W     = cnt_width(LINES);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       smi_nwe = 1'b1;
    logic [7:0] smi_data = 8'h00;
    logic       frame_opto = 1'b0;
    logic       busy, frame_rst, err;

    smi_line_rx_if #(.LED_W(LED_W), .LINE_W(LINE_W)) lb ();

    smi_line_rx #(.LEDS(LEDS), .FIFO_LINES(FIFO_LINES), .LINES(LINES)) dut (
        .clk_i(clk), .global_rst_n(rst_n), .smi_nwe_i(smi_nwe), .smi_data_i(smi_data),
        .frame_opto_i(frame_opto), .busy_o(busy), .frame_rst_o(frame_rst), .err_o(err),
        .lb(lb.master));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] got_rec[$];
    logic [63:0] exp_rec[$];
    int got_cyc[$];
    int exp_cyc[$];
    logic [7:0] m_part[$];
    int m_words = 0;
    bit m_err = 1'b0;

    function automatic logic [63:0] rec(input int line, input int led, input bit done, input logic [31:0] d);
        return {8'(line), 8'(led), 15'd0, done, d};
    endfunction

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (lb.wr_en_o === 1'b1) begin
            got_rec.push_back(rec(int'(lb.wr_line_o), int'(lb.wr_led_o), lb.line_done_o, lb.wr_data_o));
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: the n-th whole word since the frame edge is LED n%LEDS of line n/LEDS.
    task automatic model_commit(input logic [7:0] b, input int rise_cyc);
        int led, line;
`ifdef SMI_LINE_RX_OVERRUN_EN
        if (m_words >= LINES * LEDS) begin
            m_err = 1'b1;
            return;
        end
`endif
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            led  = m_words % LEDS;
            line = (m_words / LEDS) % LINES;
            exp_rec.push_back(rec(line, led, led == LEDS - 1, {m_part[3], m_part[2], m_part[1], m_part[0]}));
            exp_cyc.push_back(rise_cyc + 4);
            m_words++;
            m_part.delete();
        end
    endtask

    task automatic model_frame();
`ifdef SMI_LINE_RX_OVERRUN_EN
        if (m_part.size() != 0) m_err = 1'b1;
`endif
        m_part.delete();
        m_words = 0;
    endtask

    task automatic clear_queues();
        got_rec.delete();
        got_cyc.delete();
        exp_rec.delete();
        exp_cyc.delete();
    endtask

    // One host write: 30 set-up, 60 low, 60+ high.
    task automatic write_byte(input logic [7:0] b);
        int rc;
        @(posedge clk);
        #3 smi_data = b;
        repeat (3) @(posedge clk);
        #3 smi_nwe = 1'b0;
        repeat (6) @(posedge clk);
        #3 smi_nwe = 1'b1;
        rc = cyc;
        model_commit(b, rc);
        repeat (6) @(posedge clk);
    endtask

    task automatic pulse_frame();
        @(posedge clk);
        #3 frame_opto = 1'b1;
        repeat (4) @(posedge clk);
        #3 frame_opto = 1'b0;
        repeat (6) @(posedge clk);
        model_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lb.free_lines_i = 8'd8;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lb.wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b expected=0", lb.wr_en_o); end
        checks++; if (lb.line_done_o !== 1'b0) begin failures++; $display("FAIL reset_line_done got=%b expected=0", lb.line_done_o); end
        checks++; if (lb.wr_data_o !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h expected=0", lb.wr_data_o); end
        checks++; if (frame_rst !== 1'b0) begin failures++; $display("FAIL reset_frame_rst got=%b expected=0", frame_rst); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b expected=0", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b expected=1", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b expected=0", busy); end
    endtask

    task automatic test_single_line();
        clear_queues();
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        checks++; if (got_rec.size() !== 2) begin failures++; $display("FAIL single_count got=%0d expected=2", got_rec.size()); end
        if (got_rec.size() == 2) begin
            checks++; if (got_rec[0] !== rec(0, 0, 0, 32'h04030201)) begin failures++; $display("FAIL single_word0 got=%h expected=%h", got_rec[0], rec(0, 0, 0, 32'h04030201)); end
            checks++; if (got_rec[1] !== rec(0, 1, 1, 32'h08070605)) begin failures++; $display("FAIL single_word1 got=%h expected=%h", got_rec[1], rec(0, 1, 1, 32'h08070605)); end
            for (int i = 0; i < 2; i++) begin
                checks++; if (got_cyc[i] !== exp_cyc[i]) begin failures++; $display("FAIL single_latency[%0d] got_cycle=%0d expected_cycle=%0d", i, got_cyc[i], exp_cyc[i]); end
            end
        end
    endtask

    task automatic test_frame_mid_line();
        clear_queues();
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        pulse_frame();
        #1;
        checks++; if (frame_rst !== 1'b1) begin failures++; $display("FAIL frame_set got=%b expected=1", frame_rst); end
        write_byte(8'($urandom));
        #1;
        checks++; if (frame_rst !== 1'b0) begin failures++; $display("FAIL frame_clear got=%b expected=0", frame_rst); end
        for (int i = 0; i < 7; i++) write_byte(8'($urandom));
        checks++; if (got_rec.size() !== exp_rec.size()) begin failures++; $display("FAIL frame_count got=%0d expected=%0d", got_rec.size(), exp_rec.size()); end
        for (int i = 0; i < got_rec.size() && i < exp_rec.size(); i++) begin
            checks++; if (got_rec[i] !== exp_rec[i] || got_cyc[i] !== exp_cyc[i]) begin failures++; $display("FAIL frame_word[%0d] got=%h@%0d expected=%h@%0d", i, got_rec[i], got_cyc[i], exp_rec[i], exp_cyc[i]); end
        end
        if (got_rec.size() >= 2) begin
            checks++; if (got_rec[1][63:48] !== 16'h0000) begin failures++; $display("FAIL frame_first_index got=%h expected=0000", got_rec[1][63:48]); end
        end
        checks++; if (err !== m_err) begin failures++; $display("FAIL frame_err got=%b expected=%b", err, m_err); end
    endtask

    task automatic test_simultaneous();
        pulse_frame();
        for (int i = 0; i < 3; i++) write_byte(8'($urandom));
        clear_queues();
        @(posedge clk);
        #3 smi_data = 8'($urandom);
        repeat (3) @(posedge clk);
        #3 smi_nwe = 1'b0;
        repeat (6) @(posedge clk);
        #3 begin
            smi_nwe = 1'b1;
            frame_opto = 1'b1;
        end
        repeat (4) @(posedge clk);
        #3 frame_opto = 1'b0;
        repeat (6) @(posedge clk);
        model_frame();
        #1;
        checks++; if (frame_rst !== 1'b1) begin failures++; $display("FAIL simul_frame_rst got=%b expected=1", frame_rst); end
        checks++; if (got_rec.size() !== 0) begin failures++; $display("FAIL simul_no_write got=%0d expected=0", got_rec.size()); end
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        checks++; if (got_rec.size() !== 1 || exp_rec.size() != 1) begin failures++; $display("FAIL simul_count got=%0d expected=1", got_rec.size()); end
        if (got_rec.size() == 1 && exp_rec.size() == 1) begin
            checks++; if (got_rec[0] !== exp_rec[0]) begin failures++; $display("FAIL simul_word got=%h expected=%h", got_rec[0], exp_rec[0]); end
        end
        checks++; if (err !== m_err) begin failures++; $display("FAIL simul_err got=%b expected=%b", err, m_err); end
    endtask

    task automatic test_burst_busy();
        int nbytes;
        nbytes = FIFO_LINES * LEDS * BYTES_PER_LED;
        pulse_frame();
        clear_queues();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_idle_busy got=%b expected=0", busy); end
        for (int i = 0; i < nbytes; i++) begin
            write_byte(8'($urandom));
            #1;
            checks++;
            if (busy !== (i < nbytes - 1)) begin failures++; $display("FAIL burst_busy[%0d] got=%b expected=%b", i, busy, i < nbytes - 1); end
        end
        checks++; if (got_rec.size() !== exp_rec.size()) begin failures++; $display("FAIL burst_count got=%0d expected=%0d", got_rec.size(), exp_rec.size()); end
        for (int i = 0; i < got_rec.size() && i < exp_rec.size(); i++) begin
            checks++; if (got_rec[i] !== exp_rec[i] || got_cyc[i] !== exp_cyc[i]) begin failures++; $display("FAIL burst_word[%0d] got=%h@%0d expected=%h@%0d", i, got_rec[i], got_cyc[i], exp_rec[i], exp_cyc[i]); end
        end
        lb.free_lines_i = 8'(FIFO_LINES - 1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_low_free got=%b expected=1", busy); end
        lb.free_lines_i = 8'd8;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_free_restored got=%b expected=0", busy); end
    endtask

    task automatic test_overrun();
        int want;
`ifdef SMI_LINE_RX_OVERRUN_EN
        want = LINES * LEDS;
`else
        want = (LINES + 1) * LEDS;
`endif
        pulse_frame();
        clear_queues();
        for (int i = 0; i < (LINES + 1) * LEDS * BYTES_PER_LED; i++) write_byte(8'($urandom));
        checks++; if (got_rec.size() !== want) begin failures++; $display("FAIL overrun_count got=%0d expected=%0d", got_rec.size(), want); end
        for (int i = 0; i < got_rec.size() && i < exp_rec.size(); i++) begin
            checks++; if (got_rec[i] !== exp_rec[i] || got_cyc[i] !== exp_cyc[i]) begin failures++; $display("FAIL overrun_word[%0d] got=%h@%0d expected=%h@%0d", i, got_rec[i], got_cyc[i], exp_rec[i], exp_cyc[i]); end
        end
`ifdef SMI_LINE_RX_OVERRUN_EN
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL overrun_err got=%b expected=1", err); end
`else
        if (got_rec.size() > 0) begin
            checks++; if (got_rec[got_rec.size()-1][63:56] !== 8'h00) begin failures++; $display("FAIL overrun_wrap_line got=%0d expected=0", got_rec[got_rec.size()-1][63:56]); end
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL overrun_err got=%b expected=0", err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_frame_mid_line();
        test_simultaneous();
        test_burst_busy();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
